// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared ME constants and the bsg_cache packet width helper.
package bp_me_pkg;

    localparam int bsg_cache_opcode_width_lp = 5;

    // opcode + address + data + byte mask
    function automatic int bsg_cache_pkt_width_f(input int paddr_width, input int dword_width);
        return bsg_cache_opcode_width_lp + paddr_width + dword_width + dword_width / 8;
    endfunction

endpackage

`ifndef BSG_CACHE_PKT_WIDTH
`define BSG_CACHE_PKT_WIDTH(addr_mp, data_mp) (bp_me_pkg::bsg_cache_pkt_width_f(addr_mp, data_mp))
`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small circular-buffer FIFO with valid/ready in and valid/yumi out.
module bsg_fifo_1r1w_small
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr, wptr;
    logic [cnt_w-1:0]   cnt;
    logic               push, pop;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (cnt != cnt_w'(els_p));
    assign v_o     = (cnt != '0);
    assign data_o  = mem[rptr];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (!push && pop) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bp_me_cache_pkt_arbiter.sv
// rtl/bp_me_cache_pkt_arbiter.sv - round-robin sharing of one bsg_cache port with in-order response routing.
// Optional packet locking for contiguous multi-word sequences: BP_ME_CACHE_PKT_ARB_LOCK_EN.
module bp_me_cache_pkt_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int paddr_width_p     = 40,
    parameter int dword_width_p     = 64,
    parameter int max_outstanding_p = 4,
    localparam int pkt_w = `BSG_CACHE_PKT_WIDTH(paddr_width_p, dword_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [num_req_p*pkt_w-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]       req_v_i,
    output logic [num_req_p-1:0]       req_ready_o,
`ifdef BP_ME_CACHE_PKT_ARB_LOCK_EN
    input  logic [num_req_p-1:0]       req_lock_i,
`endif
    output logic [dword_width_p-1:0]   resp_data_o,
    output logic [num_req_p-1:0]       resp_v_o,
    input  logic [num_req_p-1:0]       resp_yumi_i,
    output logic [pkt_w-1:0]           cache_pkt_o,
    output logic                       v_o,
    input  logic                       ready_i,
    input  logic [dword_width_p-1:0]   data_i,
    input  logic                       v_i,
    output logic                       yumi_o
);

    localparam int id_w  = $clog2(num_req_p);
    localparam int cnt_w = $clog2(max_outstanding_p + 1);

    logic [id_w-1:0]      rr_ptr, grant, head, next_ptr;
    logic [cnt_w-1:0]     count;
    logic [num_req_p-1:0] req_cand;
    logic                 grant_v, credit_ok, fire, rr_adv;
    logic                 fifo_ready, fifo_v;
    int                   idx;

`ifdef BP_ME_CACHE_PKT_ARB_LOCK_EN
    logic            locked;
    logic [id_w-1:0] lock_id;

    assign req_cand = locked ? (req_v_i & (num_req_p'(1) << lock_id)) : req_v_i;
    assign rr_adv   = fire & ~req_lock_i[grant];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (fire) begin
            locked  <= req_lock_i[grant];
            lock_id <= grant;
        end
    end
`else
    assign req_cand = req_v_i;
    assign rr_adv   = fire;
`endif

    // Walk downward so the candidate closest to rr_ptr is the one left in grant.
    always_comb begin
        grant   = rr_ptr;
        grant_v = 1'b0;
        idx     = 0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (req_cand[idx]) begin
                grant   = id_w'(idx);
                grant_v = 1'b1;
            end
        end
    end

    assign next_ptr    = (grant == id_w'(num_req_p - 1)) ? '0 : grant + 1'b1;
    assign credit_ok   = (count < cnt_w'(max_outstanding_p)) & fifo_ready;
    assign v_o         = ~reset_i & grant_v & credit_ok;
    assign fire        = v_o & ready_i;
    assign cache_pkt_o = req_pkt_i[int'(grant)*pkt_w +: pkt_w];

    always_comb begin
        req_ready_o = '0;
        if (!reset_i && grant_v && credit_ok && ready_i) req_ready_o[grant] = 1'b1;
    end

    // Responses return in issue order, so the queue head names the owner.
    always_comb begin
        resp_v_o = '0;
        if (!reset_i && v_i && fifo_v) resp_v_o[head] = 1'b1;
    end

    assign resp_data_o = data_i;
    assign yumi_o      = ~reset_i & v_i & fifo_v & resp_yumi_i[head];

    bsg_fifo_1r1w_small #(
        .width_p (id_w),
        .els_p   (max_outstanding_p)
    ) id_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fire),
        .ready_o (fifo_ready),
        .data_i  (grant),
        .v_o     (fifo_v),
        .data_o  (head),
        .yumi_i  (yumi_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            if (rr_adv) rr_ptr <= next_ptr;
            if (fire && !yumi_o)      count <= count + 1'b1;
            else if (!fire && yumi_o) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(v_i && !fifo_v));
    end

endmodule

// File: tb/tb_bp_me_cache_pkt_arbiter.sv
// tb/tb_bp_me_cache_pkt_arbiter.sv - directed scoreboard bench for bp_me_cache_pkt_arbiter.
module tb_bp_me_cache_pkt_arbiter;
    import bp_me_pkg::*;

    localparam int nr = 2;
    localparam int aw = 40;
    localparam int dw = 64;
    localparam int mo = 4;
    localparam int pw = bsg_cache_pkt_width_f(aw, dw);

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } sb_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [nr*pw-1:0] req_pkt = '0;
    logic [nr-1:0]   req_v = '0, req_ready, resp_v, resp_yumi = '0, lock_v = '0;
    logic [dw-1:0]   resp_data, data = '0;
    logic [pw-1:0]   cache_pkt;
    logic            v_o, ready = 1'b0, v_i = 1'b0, yumi;

    sb_t sb[$];
    int  grants[$];
    int  seq[nr];
    int  m_rr = 0, m_cnt = 0, m_locked = 0, m_lid = 0, n_op = 0, cyc = 0;
    bit  cache_auto = 1'b0;
    int  n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    bp_me_cache_pkt_arbiter #(
        .num_req_p         (nr),
        .paddr_width_p     (aw),
        .dword_width_p     (dw),
        .max_outstanding_p (mo)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_pkt_i   (req_pkt),
        .req_v_i     (req_v),
        .req_ready_o (req_ready),
`ifdef BP_ME_CACHE_PKT_ARB_LOCK_EN
        .req_lock_i  (lock_v),
`endif
        .resp_data_o (resp_data),
        .resp_v_o    (resp_v),
        .resp_yumi_i (resp_yumi),
        .cache_pkt_o (cache_pkt),
        .v_o         (v_o),
        .ready_i     (ready),
        .data_i      (data),
        .v_i         (v_i),
        .yumi_o      (yumi)
    );

    function automatic logic [pw-1:0] mkpkt(input int i, input int s);
        logic [pw-1:0] p;
        p = '0;
        p[31:0] = 32'(s);
        p[39:32] = 8'(i + 1);
        p[pw-1 -: 8] = 8'hC3 ^ 8'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then advance the model.
    task automatic step(input logic [nr-1:0] rv, input logic rdy,
                        input logic [nr-1:0] ry, input logic [nr-1:0] lk);
        int g, idx;
        bit gv, ev, fire, ey;
        logic [nr-1:0] exp_ready, exp_resp;
        @(negedge clk);
        req_v = rv;
        ready = rdy;
        resp_yumi = ry;
        lock_v = lk;
        for (int i = 0; i < nr; i++) req_pkt[i*pw +: pw] = mkpkt(i, seq[i]);
        v_i = cache_auto && sb.size() > 0 && sb[0].due <= cyc;
        data = v_i ? sb[0].data : 64'hDEAD_0000_0000_BEEF;
        #1;
        gv = 1'b0;
        g = 0;
        for (int k = nr - 1; k >= 0; k--) begin
            idx = (m_rr + k) % nr;
            if (rv[idx] && (m_locked == 0 || idx == m_lid)) begin
                g = idx;
                gv = 1'b1;
            end
        end
        ev = gv && (m_cnt < mo);
        exp_ready = '0;
        if (ev && rdy) exp_ready[g] = 1'b1;
        chk("v_o", v_o, ev);
        chk("req_ready", req_ready, exp_ready);
        if (ev) chk("cache_pkt", cache_pkt, mkpkt(g, seq[g]));
        exp_resp = '0;
        ey = 1'b0;
        if (v_i) begin
            exp_resp[sb[0].id] = 1'b1;
            ey = ry[sb[0].id];
            chk("resp_data", resp_data, sb[0].data);
        end
        chk("resp_v", resp_v, exp_resp);
        chk("yumi", yumi, ey);
        fire = ev && rdy;
        if (ey) void'(sb.pop_front());
        if (fire) begin
            sb.push_back('{g, 64'hA0 + 64'(n_op), cyc + 2});
            n_op++;
            seq[g]++;
            grants.push_back(g);
            if (lk[g]) begin
                m_locked = 1;
                m_lid = g;
            end else begin
                m_locked = 0;
                m_rr = (g + 1) % nr;
            end
        end
        if (fire && !ey) m_cnt++;
        else if (!fire && ey) m_cnt--;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_v = '1;
        ready = 1'b1;
        v_i = 1'b0;
        resp_yumi = '1;
        lock_v = '0;
        #1;
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_v", resp_v, '0);
        chk("rst_yumi", yumi, 1'b0);
        @(negedge clk);
        req_v = '0;
        ready = 1'b0;
        resp_yumi = '0;
        reset = 1'b0;
        sb.delete();
        grants.delete();
        m_rr = 0;
        m_cnt = 0;
        m_locked = 0;
        cyc = 0;
    endtask

    initial begin
        for (int i = 0; i < nr; i++) seq[i] = 0;

        // idle after reset, then alternating grants with 2-cycle cache latency
        do_reset();
        cache_auto = 1'b1;
        for (int i = 0; i < 5; i++) step(2'b00, 1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 8; i++) step(2'b11, 1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 2'b11, 2'b00);
        chk("alt_drain", sb.size(), 0);
        chk("alt_g0", grants[0], 0);
        chk("alt_g1", grants[1], 1);
        chk("alt_g2", grants[2], 0);
        chk("alt_g3", grants[3], 1);

        // credit exhaustion: exactly max_outstanding_p fires, one-cycle recovery
        do_reset();
        cache_auto = 1'b0;
        for (int i = 0; i < 6; i++) step(2'b11, 1'b1, 2'b11, 2'b00);
        chk("full_fires", grants.size(), mo);
        cache_auto = 1'b1;
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 2'b11, 2'b00);
        chk("full_recover_fires", grants.size(), mo + 2);
        for (int i = 0; i < 10; i++) step(2'b00, 1'b1, 2'b11, 2'b00);
        chk("full_drain", sb.size(), 0);

        // cache backpressure holds the packet
        do_reset();
        cache_auto = 1'b1;
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 2'b11, 2'b00);
        chk("bp_no_fire", grants.size(), 0);
        step(2'b01, 1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 2'b11, 2'b00);
        chk("bp_fires", grants.size(), 1);
        chk("bp_drain", sb.size(), 0);

        // only the head owner's yumi pops
        do_reset();
        cache_auto = 1'b0;
        step(2'b10, 1'b1, 2'b00, 2'b00);
        step(2'b00, 1'b0, 2'b00, 2'b00);
        cache_auto = 1'b1;
        step(2'b00, 1'b0, 2'b01, 2'b00);
        step(2'b00, 1'b0, 2'b01, 2'b00);
        step(2'b00, 1'b0, 2'b10, 2'b00);
        step(2'b00, 1'b0, 2'b11, 2'b00);
        chk("head_drain", sb.size(), 0);

        // reset mid-operation discards stale IDs
        do_reset();
        cache_auto = 1'b0;
        step(2'b10, 1'b1, 2'b00, 2'b00);
        step(2'b10, 1'b1, 2'b00, 2'b00);
        do_reset();
        cache_auto = 1'b1;
        step(2'b01, 1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 2'b11, 2'b00);
        chk("rst_mid_drain", sb.size(), 0);

`ifdef BP_ME_CACHE_PKT_ARB_LOCK_EN
        // locked burst from requester 0 stays contiguous
        do_reset();
        cache_auto = 1'b1;
        step(2'b11, 1'b1, 2'b11, 2'b01);
        step(2'b11, 1'b1, 2'b11, 2'b01);
        step(2'b11, 1'b1, 2'b11, 2'b01);
        step(2'b11, 1'b1, 2'b11, 2'b00);
        step(2'b11, 1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 2'b11, 2'b00);
        chk("lock_g0", grants[0], 0);
        chk("lock_g1", grants[1], 0);
        chk("lock_g2", grants[2], 0);
        chk("lock_g3", grants[3], 0);
        chk("lock_g4", grants[4], 1);
        chk("lock_drain", sb.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
